// File: rtl/enigma_merge_if.sv
// Signal bundle between the two request sources, the merger and the downstream consumer.
// master = merger view, slave = environment (sources plus consumer) view.
interface enigma_merge_if;
  logic [127:0] payload_a;
  logic [4:0]   id_a;
  logic [1:0]   qos_a;
  logic         valid_a;
  logic         ready_a;

  logic [127:0] payload_b;
  logic [4:0]   id_b;
  logic [1:0]   qos_b;
  logic         valid_b;
  logic         ready_b;

  logic [127:0] payload_c;
  logic [5:0]   id_c;
  logic [1:0]   qos_c;
  logic         valid_c;
  logic         ready_c;
  logic         conflict_c;
  logic         release_c;
  logic [5:0]   releaseid_c;
  logic         err;

  modport master (
    input  payload_a, id_a, qos_a, valid_a,
    output ready_a,
    input  payload_b, id_b, qos_b, valid_b,
    output ready_b,
    output payload_c, id_c, qos_c, valid_c,
    input  ready_c, conflict_c, release_c, releaseid_c,
    output err
  );

  modport slave (
    output payload_a, id_a, qos_a, valid_a,
    input  ready_a,
    output payload_b, id_b, qos_b, valid_b,
    input  ready_b,
    input  payload_c, id_c, qos_c, valid_c,
    output ready_c, conflict_c, release_c, releaseid_c,
    input  err
  );
endinterface

// File: rtl/enigma_merge.sv
// Two-port to one-port request merger: qos + round-robin arbitration into a one-beat slot, outstanding-id tracking.
// Optional ENIGMA_QOS_AGING_EN: per-port loss counters promote a starved port to top qos.
module enigma_merge #(
  parameter bit          RR_INIT   = 1'b0,
  parameter int unsigned AGE_LIMIT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  enigma_merge_if.master mrg_if
);

  localparam logic [3:0] AGE_LIM = 4'(AGE_LIMIT);

  logic         valid_q, valid_d;
  logic [127:0] payload_q, payload_d;
  logic [5:0]   id_q, id_d;
  logic [1:0]   qos_q, qos_d;
  logic [63:0]  outst_q, outst_d;
  logic         rr_q, rr_d;
  logic         err_q, err_d;

  logic         accept;
  logic         slot_free;
  logic [5:0]   cid_a, cid_b;
  logic         elig_a, elig_b;
  logic [1:0]   eff_qos_a, eff_qos_b;
  logic         tie, win_a, win_b;

  assign accept    = valid_q & mrg_if.ready_c & ~mrg_if.conflict_c;
  assign slot_free = ~valid_q | accept;

  assign cid_a = {1'b0, mrg_if.id_a};
  assign cid_b = {1'b1, mrg_if.id_b};

  // A release of the very id a port presents unblocks it in the same cycle.
  assign elig_a = mrg_if.valid_a &
                  (~outst_q[cid_a] | (mrg_if.release_c & (mrg_if.releaseid_c == cid_a)));
  assign elig_b = mrg_if.valid_b &
                  (~outst_q[cid_b] | (mrg_if.release_c & (mrg_if.releaseid_c == cid_b)));

`ifdef ENIGMA_QOS_AGING_EN
  logic [3:0] age_a_q, age_a_d, age_b_q, age_b_d;

  assign eff_qos_a = (age_a_q >= AGE_LIM) ? 2'd3 : mrg_if.qos_a;
  assign eff_qos_b = (age_b_q >= AGE_LIM) ? 2'd3 : mrg_if.qos_b;

  always_comb begin
    age_a_d = age_a_q;
    age_b_d = age_b_q;
    if (win_a) begin
      age_a_d = 4'd0;
    end else if (slot_free && elig_a && (age_a_q != 4'hF)) begin
      age_a_d = age_a_q + 4'd1;
    end
    if (win_b) begin
      age_b_d = 4'd0;
    end else if (slot_free && elig_b && (age_b_q != 4'hF)) begin
      age_b_d = age_b_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      age_a_q <= 4'd0;
      age_b_q <= 4'd0;
    end else begin
      age_a_q <= age_a_d;
      age_b_q <= age_b_d;
    end
  end
`else
  logic unused_age_cfg;
  assign unused_age_cfg = ^AGE_LIM;
  assign eff_qos_a      = mrg_if.qos_a;
  assign eff_qos_b      = mrg_if.qos_b;
`endif

  // Grants are held off during reset so nothing is loaded before the slot is clean.
  always_comb begin
    tie   = 1'b0;
    win_a = 1'b0;
    win_b = 1'b0;
    if (slot_free && rst_n) begin
      if (elig_a && elig_b) begin
        if (eff_qos_a > eff_qos_b) begin
          win_a = 1'b1;
        end else if (eff_qos_b > eff_qos_a) begin
          win_b = 1'b1;
        end else begin
          tie   = 1'b1;
          win_a = ~rr_q;
          win_b = rr_q;
        end
      end else begin
        win_a = elig_a;
        win_b = elig_b;
      end
    end
  end

  assign mrg_if.ready_a = win_a;
  assign mrg_if.ready_b = win_b;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    id_d      = id_q;
    qos_d     = qos_q;
    rr_d      = rr_q;
    err_d     = err_q;
    outst_d   = outst_q;

    if (win_a) begin
      valid_d   = 1'b1;
      payload_d = mrg_if.payload_a;
      id_d      = cid_a;
      qos_d     = mrg_if.qos_a;
    end else if (win_b) begin
      valid_d   = 1'b1;
      payload_d = mrg_if.payload_b;
      id_d      = cid_b;
      qos_d     = mrg_if.qos_b;
    end else if (accept) begin
      valid_d = 1'b0;
    end

    if (tie) begin
      rr_d = ~rr_q;
    end

    // Clear first, then set, so a same-cycle set of the same id wins.
    if (mrg_if.release_c) begin
      outst_d[mrg_if.releaseid_c] = 1'b0;
    end
    if (accept) begin
      outst_d[id_q] = 1'b1;
    end

    if (mrg_if.release_c && !outst_q[mrg_if.releaseid_c] &&
        !(accept && (id_q == mrg_if.releaseid_c))) begin
      err_d = 1'b1;
    end

    // A presented beat must stay frozen until the consumer takes it.
    if (valid_q && !accept &&
        (!valid_d || (payload_d != payload_q) || (id_d != id_q) || (qos_d != qos_q))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      id_q      <= '0;
      qos_q     <= '0;
      outst_q   <= '0;
      rr_q      <= RR_INIT;
      err_q     <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      id_q      <= id_d;
      qos_q     <= qos_d;
      outst_q   <= outst_d;
      rr_q      <= rr_d;
      err_q     <= err_d;
    end
  end

  assign mrg_if.valid_c   = valid_q;
  assign mrg_if.payload_c = payload_q;
  assign mrg_if.id_c      = id_q;
  assign mrg_if.qos_c     = qos_q;
  assign mrg_if.err       = err_q;

endmodule

// File: tb/tb_enigma_merge.sv
// Bench for enigma_merge: directed scenarios plus a randomized run against a transaction-level reference model.
module tb_enigma_merge;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  enigma_merge_if bus();

  enigma_merge #(.RR_INIT(1'b0), .AGE_LIMIT(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mrg_if (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic drive_idle();
    bus.payload_a   = '0;
    bus.id_a        = '0;
    bus.qos_a       = '0;
    bus.valid_a     = 1'b0;
    bus.payload_b   = '0;
    bus.id_b        = '0;
    bus.qos_b       = '0;
    bus.valid_b     = 1'b0;
    bus.ready_c     = 1'b0;
    bus.conflict_c  = 1'b0;
    bus.release_c   = 1'b0;
    bus.releaseid_c = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [127:0] rand_payload();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    bus.valid_a = 1'b1;
    bus.valid_b = 1'b1;
    bus.id_a    = 5'd1;
    bus.id_b    = 5'd2;
    bus.ready_c = 1'b1;
    step();
    step();
    #1;
    checks++;
    if (bus.valid_c !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_err: valid_c=%0b err=%0b expected 0 0", bus.valid_c, bus.err);
    end
    checks++;
    if (bus.ready_a !== 1'b0 || bus.ready_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: ready_a=%0b ready_b=%0b expected 0 0", bus.ready_a, bus.ready_b);
    end
    checks++;
    if (bus.payload_c !== 128'd0 || bus.id_c !== 6'd0 || bus.qos_c !== 2'd0) begin
      errors++;
      $display("FAIL reset_slot: payload_c=%h id_c=%h qos_c=%0d expected 0", bus.payload_c, bus.id_c, bus.qos_c);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.valid_c !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_valid_c: got %0b expected 0", bus.valid_c);
    end
    drive_idle();
  endtask

  task automatic test_single_beat();
    logic [127:0] pay;
    do_reset();
    pay = rand_payload();
    bus.valid_a   = 1'b1;
    bus.qos_a     = 2'd1;
    bus.id_a      = 5'd5;
    bus.payload_a = pay;
    bus.ready_c   = 1'b1;
    #1;
    checks++;
    if (bus.ready_a !== 1'b1 || bus.ready_b !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: ready_a=%0b ready_b=%0b expected 1 0", bus.ready_a, bus.ready_b);
    end
    step();
    bus.valid_a = 1'b0;
    checks++;
    if (bus.valid_c !== 1'b1 || bus.id_c !== 6'h05 || bus.qos_c !== 2'd1 || bus.payload_c !== pay) begin
      errors++;
      $display("FAIL single_out: valid_c=%0b id_c=%h qos_c=%0d payload_c=%h expected 1 05 1 %h",
               bus.valid_c, bus.id_c, bus.qos_c, bus.payload_c, pay);
    end
    step();
    checks++;
    if (bus.valid_c !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: valid_c=%0b expected 0", bus.valid_c);
    end
    bus.valid_a = 1'b1;
    #1;
    checks++;
    if (bus.ready_a !== 1'b0) begin
      errors++;
      $display("FAIL single_outstanding: ready_a=%0b expected 0 (id 5 outstanding)", bus.ready_a);
    end
    drive_idle();
  endtask

  task automatic test_qos_priority();
    do_reset();
    bus.valid_a = 1'b1;
    bus.qos_a   = 2'd1;
    bus.id_a    = 5'd3;
    bus.valid_b = 1'b1;
    bus.qos_b   = 2'd3;
    bus.id_b    = 5'd9;
    bus.ready_c = 1'b1;
    #1;
    checks++;
    if (bus.ready_b !== 1'b1 || bus.ready_a !== 1'b0) begin
      errors++;
      $display("FAIL qos_first: ready_a=%0b ready_b=%0b expected 0 1", bus.ready_a, bus.ready_b);
    end
    step();
    bus.valid_b = 1'b0;
    checks++;
    if (bus.valid_c !== 1'b1 || bus.id_c !== 6'h29 || bus.qos_c !== 2'd3) begin
      errors++;
      $display("FAIL qos_out_b: valid_c=%0b id_c=%h qos_c=%0d expected 1 29 3", bus.valid_c, bus.id_c, bus.qos_c);
    end
    #1;
    checks++;
    if (bus.ready_a !== 1'b1) begin
      errors++;
      $display("FAIL qos_second: ready_a=%0b expected 1", bus.ready_a);
    end
    step();
    bus.valid_a = 1'b0;
    checks++;
    if (bus.valid_c !== 1'b1 || bus.id_c !== 6'h03 || bus.qos_c !== 2'd1) begin
      errors++;
      $display("FAIL qos_out_a: valid_c=%0b id_c=%h qos_c=%0d expected 1 03 1", bus.valid_c, bus.id_c, bus.qos_c);
    end
    drive_idle();
  endtask

  task automatic test_round_robin();
    logic       exp_src;
    logic [4:0] ida, idb;
    do_reset();
    ida = 5'd0;
    idb = 5'd10;
    exp_src = 1'b0;
    bus.valid_a = 1'b1;
    bus.valid_b = 1'b1;
    bus.qos_a   = 2'd2;
    bus.qos_b   = 2'd2;
    bus.id_a    = ida;
    bus.id_b    = idb;
    bus.ready_c = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (bus.ready_a !== ~exp_src || bus.ready_b !== exp_src) begin
        errors++;
        $display("FAIL rr_grant_%0d: ready_a=%0b ready_b=%0b expected %0b %0b",
                 k, bus.ready_a, bus.ready_b, ~exp_src, exp_src);
      end
      step();
      checks++;
      if (bus.valid_c !== 1'b1 || bus.id_c !== {exp_src, (exp_src ? idb : ida)}) begin
        errors++;
        $display("FAIL rr_out_%0d: valid_c=%0b id_c=%h expected 1 %h",
                 k, bus.valid_c, bus.id_c, {exp_src, (exp_src ? idb : ida)});
      end
      if (exp_src) idb = idb + 5'd1;
      else         ida = ida + 5'd1;
      bus.id_a = ida;
      bus.id_b = idb;
      exp_src = ~exp_src;
    end
    drive_idle();
  endtask

  task automatic test_conflict();
    logic [127:0] pay;
    do_reset();
    pay = rand_payload();
    bus.valid_b   = 1'b1;
    bus.id_b      = 5'h03;
    bus.qos_b     = 2'd2;
    bus.payload_b = pay;
    bus.ready_c   = 1'b0;
    step();
    bus.valid_b = 1'b0;
    checks++;
    if (bus.valid_c !== 1'b1 || bus.id_c !== 6'h23) begin
      errors++;
      $display("FAIL conflict_load: valid_c=%0b id_c=%h expected 1 23", bus.valid_c, bus.id_c);
    end
    bus.ready_c    = 1'b1;
    bus.conflict_c = 1'b1;
    step();
    checks++;
    if (bus.valid_c !== 1'b1 || bus.id_c !== 6'h23 || bus.payload_c !== pay || bus.qos_c !== 2'd2) begin
      errors++;
      $display("FAIL conflict_hold: valid_c=%0b id_c=%h payload_c=%h expected 1 23 %h",
               bus.valid_c, bus.id_c, bus.payload_c, pay);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL conflict_err_clean: err=%0b expected 0", bus.err);
    end
    // Releasing 0x23 now must flag an error, proving the conflicted beat left the bit clear.
    bus.ready_c     = 1'b0;
    bus.conflict_c  = 1'b0;
    bus.release_c   = 1'b1;
    bus.releaseid_c = 6'h23;
    step();
    bus.release_c = 1'b0;
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL conflict_not_outstanding: err=%0b expected 1", bus.err);
    end
    bus.ready_c = 1'b1;
    step();
    checks++;
    if (bus.valid_c !== 1'b0) begin
      errors++;
      $display("FAIL conflict_accept: valid_c=%0b expected 0", bus.valid_c);
    end
    bus.valid_b = 1'b1;
    bus.id_b    = 5'h03;
    #1;
    checks++;
    if (bus.ready_b !== 1'b0) begin
      errors++;
      $display("FAIL conflict_outstanding_set: ready_b=%0b expected 0", bus.ready_b);
    end
    drive_idle();
  endtask

  task automatic test_release_bypass();
    do_reset();
    bus.valid_a = 1'b1;
    bus.id_a    = 5'd7;
    bus.qos_a   = 2'd0;
    bus.ready_c = 1'b1;
    #1;
    checks++;
    if (bus.ready_a !== 1'b1) begin
      errors++;
      $display("FAIL block_first: ready_a=%0b expected 1", bus.ready_a);
    end
    step();
    bus.valid_a = 1'b0;
    step();
    bus.valid_a = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (bus.ready_a !== 1'b0) begin
        errors++;
        $display("FAIL block_wait_%0d: ready_a=%0b expected 0", k, bus.ready_a);
      end
      step();
    end
    bus.release_c   = 1'b1;
    bus.releaseid_c = 6'h07;
    #1;
    checks++;
    if (bus.ready_a !== 1'b1) begin
      errors++;
      $display("FAIL block_bypass: ready_a=%0b expected 1", bus.ready_a);
    end
    step();
    bus.release_c = 1'b0;
    bus.valid_a   = 1'b0;
    checks++;
    if (bus.valid_c !== 1'b1 || bus.id_c !== 6'h07 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL block_second_out: valid_c=%0b id_c=%h err=%0b expected 1 07 0",
               bus.valid_c, bus.id_c, bus.err);
    end
    drive_idle();
  endtask

  task automatic test_error();
    do_reset();
    bus.release_c   = 1'b1;
    bus.releaseid_c = 6'h3F;
    step();
    bus.release_c = 1'b0;
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: err=%0b expected 1", bus.err);
    end
    step();
    step();
    step();
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%0b expected 1", bus.err);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL err_reset: err=%0b expected 0", bus.err);
    end
    rst_n = 1'b1;
  endtask

  // Reference model: each source holds one pending request until granted; the
  // consumer side keeps a set of live ids, a single presented beat and a tie turn.
  task automatic test_random(input int n);
    logic         m_vld;
    logic [127:0] m_pay;
    logic [5:0]   m_id;
    logic [1:0]   m_qos;
    logic [63:0]  m_live;
    logic         m_turn;
    logic         pa_v, pb_v;
    logic [127:0] pa_p, pb_p;
    logic [4:0]   pa_i, pb_i;
    logic [1:0]   pa_q, pb_q;
    logic         rc, cc, rl;
    logic [5:0]   rid;
    logic         taken, open, can_a, can_b, ga, gb, was_tie;
    int           start;
    do_reset();
    m_vld = 1'b0; m_pay = '0; m_id = '0; m_qos = '0; m_live = '0; m_turn = 1'b0;
    pa_v = 1'b0; pb_v = 1'b0; pa_p = '0; pb_p = '0; pa_i = '0; pb_i = '0; pa_q = '0; pb_q = '0;
    for (int cyc = 0; cyc < n; cyc++) begin
      checks++;
      if (bus.valid_c !== m_vld) begin
        errors++;
        $display("FAIL rand_valid_c cyc %0d: got %0b expected %0b", cyc, bus.valid_c, m_vld);
      end
      if (m_vld) begin
        checks++;
        if (bus.id_c !== m_id || bus.qos_c !== m_qos || bus.payload_c !== m_pay) begin
          errors++;
          $display("FAIL rand_beat cyc %0d: id_c=%h qos_c=%0d payload_c=%h expected %h %0d %h",
                   cyc, bus.id_c, bus.qos_c, bus.payload_c, m_id, m_qos, m_pay);
        end
      end
      checks++;
      if (bus.err !== 1'b0) begin
        errors++;
        $display("FAIL rand_err cyc %0d: got %0b expected 0", cyc, bus.err);
      end

      if (!pa_v && $urandom_range(1, 0) == 1) begin
        pa_v = 1'b1; pa_i = 5'($urandom_range(7, 0)); pa_q = 2'($urandom_range(3, 0)); pa_p = rand_payload();
      end
      if (!pb_v && $urandom_range(1, 0) == 1) begin
        pb_v = 1'b1; pb_i = 5'($urandom_range(7, 0)); pb_q = 2'($urandom_range(3, 0)); pb_p = rand_payload();
      end
      rc = ($urandom_range(3, 0) != 0);
      cc = ($urandom_range(4, 0) == 0);
      rl = 1'b0;
      rid = '0;
      if (m_live != 64'd0 && $urandom_range(2, 0) == 0) begin
        start = int'($urandom_range(63, 0));
        for (int k = 0; k < 64; k++) begin
          if (!rl && m_live[(start + k) % 64]) begin
            rl  = 1'b1;
            rid = 6'((start + k) % 64);
          end
        end
      end
      bus.valid_a = pa_v; bus.id_a = pa_i; bus.qos_a = pa_q; bus.payload_a = pa_p;
      bus.valid_b = pb_v; bus.id_b = pb_i; bus.qos_b = pb_q; bus.payload_b = pb_p;
      bus.ready_c = rc; bus.conflict_c = cc; bus.release_c = rl; bus.releaseid_c = rid;
      #1;

      taken = m_vld && rc && !cc;
      open  = !m_vld || taken;
      can_a = pa_v && (!m_live[{1'b0, pa_i}] || (rl && rid == {1'b0, pa_i}));
      can_b = pb_v && (!m_live[{1'b1, pb_i}] || (rl && rid == {1'b1, pb_i}));
      ga = 1'b0; gb = 1'b0; was_tie = 1'b0;
      if (open && can_a && can_b) begin
        if (pa_q == pb_q) begin
          was_tie = 1'b1;
          ga = !m_turn;
          gb = m_turn;
        end else begin
          ga = (pa_q > pb_q);
          gb = !ga;
        end
      end else if (open) begin
        ga = can_a;
        gb = can_b;
      end
      checks++;
      if (bus.ready_a !== ga || bus.ready_b !== gb) begin
        errors++;
        $display("FAIL rand_ready cyc %0d: ready_a=%0b ready_b=%0b expected %0b %0b",
                 cyc, bus.ready_a, bus.ready_b, ga, gb);
      end

      if (rl)    m_live[rid]  = 1'b0;
      if (taken) m_live[m_id] = 1'b1;
      if (ga) begin
        m_vld = 1'b1; m_pay = pa_p; m_id = {1'b0, pa_i}; m_qos = pa_q; pa_v = 1'b0;
      end else if (gb) begin
        m_vld = 1'b1; m_pay = pb_p; m_id = {1'b1, pb_i}; m_qos = pb_q; pb_v = 1'b0;
      end else if (taken) begin
        m_vld = 1'b0;
      end
      if (was_tie) m_turn = !m_turn;
      step();
    end
    drive_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_single_beat();
    test_qos_priority();
    test_round_robin();
    test_conflict();
    test_release_bypass();
    test_error();
    test_random(800);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/enigma_merge.md
Name: enigma_merge

Overview:
- Two-port to one-port request merger for the enigma interface.
- Ports A and B each carry 128-bit payload, 5-bit id and 2-bit qos beats on valid/ready. The block arbitrates them onto port C with a 6-bit id of {src, id}.
- Tracks outstanding C ids. Honours downstream conflict (retry) and release (id retirement) signalling.
- Sits between the request sources and the downstream enigma consumer. It is the DUT counterpart of the enigma simulation model.

Parameters:
- RR_INIT, 0, initial round-robin pointer after reset (0 = A preferred on tie, 1 = B).
- AGE_LIMIT, 8, consecutive lost arbitrations before a port is promoted. Used only with ENIGMA_QOS_AGING_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- payload_a  in  128  port A payload
- id_a  in  5  port A id
- qos_a  in  2  port A qos (3 = highest)
- valid_a  in  1  port A valid
- ready_a  out  1  port A ready
- payload_b  in  128  port B payload
- id_b  in  5  port B id
- qos_b  in  2  port B qos
- valid_b  in  1  port B valid
- ready_b  out  1  port B ready
- payload_c  out  128  registered output payload
- id_c  out  6  {src, id}; src 0 = A, 1 = B
- qos_c  out  2  output qos
- valid_c  out  1  output valid
- ready_c  in  1  downstream ready
- conflict_c  in  1  downstream rejects the beat handshaking this cycle
- release_c  in  1  downstream retires releaseid_c this cycle
- releaseid_c  in  6  id being retired
- err  out  1  sticky protocol error

Behaviour:
- Reset: clk and rst_n are fixed as above; reset is synchronous, active-low. On reset:
  - valid_c, ready_a, ready_b, err = 0.
  - payload_c, id_c, qos_c = 0.
  - Outstanding table (64 bits) cleared.
  - RR pointer = RR_INIT.
  - Age counters = 0.
- Output stage: one register slot.
  - accept = valid_c & ready_c & ~conflict_c.
  - The slot is free when ~valid_c, or when accept occurs this cycle.
- Conflict: when valid_c & ready_c & conflict_c, the beat is not accepted.
  - The slot holds the same payload, id and qos, and valid_c stays 1.
  - The beat re-presents from the next cycle. The outstanding bit is not set.
- Eligibility: port X is eligible when valid_x = 1 and outstanding[{src, id_x}] = 0.
  - Exception: the id is eligible if release_c retires exactly that id this cycle (release bypass).
- Arbitration (combinational, only when the slot is free):
  - Higher qos wins.
  - On equal qos, the RR pointer selects. The pointer toggles to the other port after each grant on a tie.
  - A single eligible port wins outright.
- Grant: ready_x = 1 only for the winner, in the cycle the slot is free. It is combinational from valid/qos/table/slot state.
  - On valid_x & ready_x the winner is loaded into the slot next edge, giving valid_c = 1.
  - Latency is 1 cycle from input handshake to valid_c.
  - Back-to-back throughput is 1 beat/cycle when ready_c = 1 and there is no conflict.
- Outstanding table:
  - Set bit id_c on accept.
  - Clear bit releaseid_c on release_c.
  - Simultaneous set and clear of the same bit in one cycle: set wins, so the new transaction stays outstanding.
- Error (sticky until reset):
  - release_c of an id whose bit is 0 and is not being set the same cycle sets err; the table is unchanged.
  - valid_c, payload_c, id_c and qos_c change while valid_c = 1 and no accept occurred sets err. This is an internal assertion; the check is kept in RTL.
- Reset mid-operation: the in-flight slot and all outstanding state are discarded. No beat is emitted in the cycle after rst_n rises.

Optional Feature:
- ENIGMA_QOS_AGING_EN defined:
  - Each port has a 4-bit saturating loss counter. It increments when the port is eligible but not granted while the slot is free, and clears on grant.
  - When the counter reaches AGE_LIMIT, the port's effective qos is treated as 3 for arbitration. qos_c still carries the original qos.
  - If both ports are aged, the RR pointer decides.
- Undefined: pure qos plus round-robin arbitration; no counters are synthesised.

Test Plan:
- Single beat: valid_a = 1, qos_a = 1, id_a = 5, ready_c = 1 -> ready_a = 1 at cycle 0; valid_c = 1, id_c = 0x05 at cycle 1; outstanding[5] = 1.
- QoS priority: A qos 1 and B qos 3 both valid with slot free -> B granted first with id_c = {1, id_b}; A granted the next cycle.
- Tie round-robin: A and B both qos 2, continuously valid, distinct ids, RR_INIT = 0 -> grant order A, B, A, B; id_c[5] toggles 0, 1, 0, 1.
- Conflict retry: conflict_c = 1 with handshake on id_c 0x23 -> valid_c stays 1 with identical payload; re-accepted with conflict_c = 0; outstanding[0x23] is set only then.
- Id blocking and release: A sends id 7 twice and the first is accepted -> the second sees ready_a = 0 until release_c = 1 with releaseid_c = 0x07; granted in that same cycle via bypass.
- Error: release_c with releaseid_c = 0x3F never issued -> err = 1 next cycle and stays 1 until rst_n = 0.
